mux_rr_nx1: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer; successor to the combinational 2:1 mux.
- Two selection modes:
  - Fixed: channel chosen by Sel.
  - Round-robin: fair rotation over valid inputs.
- Every input and the output use a valid/ready handshake; output is registered (1-cycle latency).
- Sits between multiple producers and a single consumer in datapath/test structures.

---
 rtl/mux_rr_nx1.sv | 155 +++++++++++++++
 tb/tb_mux_rr_nx1.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-input, WIDTH-bit registered multiplexer with valid/ready
// handshakes on every input and on the output. Mode selects between a fixed
// channel (Sel) and fair round-robin rotation over the valid inputs.
// Output register has one cycle of latency and refills in the cycle it drains.
//
// Optional build macro MUX_XFER_CNT_EN adds a 16-bit saturating count of
// output transfers on port Xfer_Cnt.
module mux_rr_nx1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Mode,
  input  logic [SELW-1:0]      Sel,
  input  logic [N*WIDTH-1:0]   In_Data,
  input  logic [N-1:0]         In_Valid,
  output logic [N-1:0]         In_Ready,
  output logic [WIDTH-1:0]     Y,
  output logic                 Y_Valid,
  input  logic                 Y_Ready,
  output logic [SELW-1:0]      Y_Ch
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]          Xfer_Cnt
`endif
);

  // Pointer value that makes the first round-robin scan start at channel 0.
  localparam logic [SELW-1:0] PTR_LAST = SELW'(N - 1);

  logic             load;
  logic [SELW-1:0]  ptr;
  logic             fix_act;
  logic             hi_act;
  logic [SELW-1:0]  hi_grant;
  logic             lo_act;
  logic [SELW-1:0]  lo_grant;
  logic             rr_act;
  logic [SELW-1:0]  rr_grant;
  logic             grant_act;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new word when it is empty or being drained.
  assign load = !Y_Valid || Y_Ready;

  // Fixed mode: grant Sel only if it names a real channel that is valid.
  // Out-of-range Sel values match no loop index and therefore never grant.
  always_comb begin
    fix_act = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((Sel == i[SELW-1:0]) && In_Valid[i]) begin
        fix_act = 1'b1;
      end else begin
        fix_act = fix_act;
      end
    end
  end

  // Round-robin: lowest valid channel above ptr wins, else lowest valid
  // channel at or below ptr (i.e. scan ptr+1, ptr+2, ... modulo N).
  always_comb begin
    hi_act   = 1'b0;
    hi_grant = {SELW{1'b0}};
    lo_act   = 1'b0;
    lo_grant = {SELW{1'b0}};
    for (int c = N - 1; c >= 0; c--) begin
      if (In_Valid[c]) begin
        if (c[SELW-1:0] > ptr) begin
          hi_act   = 1'b1;
          hi_grant = c[SELW-1:0];
        end else begin
          lo_act   = 1'b1;
          lo_grant = c[SELW-1:0];
        end
      end else begin
        hi_act = hi_act;
      end
    end
    rr_act = hi_act || lo_act;
    if (hi_act) begin
      rr_grant = hi_grant;
    end else begin
      rr_grant = lo_grant;
    end
  end

  // Choose the active grant according to the selection mode.
  always_comb begin
    if (Mode) begin
      grant_act = rr_act;
      grant     = rr_grant;
    end else begin
      grant_act = fix_act;
      grant     = Sel;
    end
  end

  // Pick the granted channel's data word.
  always_comb begin
    grant_data = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant == i[SELW-1:0]) begin
        grant_data = In_Data[i*WIDTH +: WIDTH];
      end else begin
        grant_data = grant_data;
      end
    end
  end

  // One-hot ready to the granted channel; silent during reset or when full.
  always_comb begin
    In_Ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      In_Ready[i] = !Rst && load && grant_act && (grant == i[SELW-1:0]);
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Y       <= {WIDTH{1'b0}};
      Y_Valid <= 1'b0;
      Y_Ch    <= {SELW{1'b0}};
      ptr     <= PTR_LAST;
    end else if (load) begin
      if (grant_act) begin
        Y       <= grant_data;
        Y_Ch    <= grant;
        Y_Valid <= 1'b1;
        if (Mode) begin
          ptr <= grant;
        end
      end else begin
        Y_Valid <= 1'b0;
      end
    end
  end

`ifdef MUX_XFER_CNT_EN
  // Count words taken by the consumer, saturating at all ones.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Xfer_Cnt <= 16'h0000;
    end else if (Y_Valid && Y_Ready && (Xfer_Cnt != 16'hFFFF)) begin
      Xfer_Cnt <= Xfer_Cnt + 16'h0001;
    end
  end
`else
  // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1 (N=4, WIDTH=8): directed scenarios with
// constant expectations, then randomized traffic against a behavioural model.
module tb_mux_rr_nx1;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic               y_ready;
  logic [SELW-1:0]    y_ch;
`ifdef MUX_XFER_CNT_EN
  logic [15:0]        xfer_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_y;
  bit               m_valid;
  int               m_ch;
  int               m_ptr;
  int               m_cnt;

  always #5 clk = ~clk;

  mux_rr_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk(clk),
    .Rst(rst),
    .Mode(mode),
    .Sel(sel),
    .In_Data(in_data),
    .In_Valid(in_valid),
    .In_Ready(in_ready),
    .Y(y),
    .Y_Valid(y_valid),
    .Y_Ready(y_ready),
    .Y_Ch(y_ch)
`ifdef MUX_XFER_CNT_EN
    ,
    .Xfer_Cnt(xfer_cnt)
`endif
  );

  // Channel granted by the rules for the current inputs, -1 if none.
  function automatic int exp_grant();
    if (rst) return -1;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (!rst && (!m_valid || y_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] chan(input int c);
    return in_data[c*WIDTH +: WIDTH];
  endfunction

  // Advance model by one clock using current inputs, then clock the DUT.
  task automatic step();
    int g;
    bit ld;
    g  = exp_grant();
    ld = !m_valid || y_ready;
    if (rst) begin
      m_y = '0; m_valid = 0; m_ch = 0; m_ptr = N - 1; m_cnt = 0;
    end else begin
      if (m_valid && y_ready && m_cnt < 65535) m_cnt++;
      if (ld) begin
        if (g >= 0) begin
          m_y = chan(g); m_ch = g; m_valid = 1;
          if (mode) m_ptr = g;
        end else begin
          m_valid = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; y_ready = 1'b1;
    in_valid = 4'b1111; in_data = {$urandom};
    step();
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
    step();
    n_checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || y_ch !== 2'd0) begin
      n_fail++; $display("FAIL reset_out: got y=%h v=%b ch=%0d expected 00/0/0", y, y_valid, y_ch);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_rr_ready: got %b expected 0001", in_ready); end
    step();
    n_checks++;
    if (y_ch !== 2'd0 || y_valid !== 1'b1 || y !== in_data[7:0]) begin
      n_fail++; $display("FAIL reset_first_rr: got ch=%0d v=%b y=%h expected 0/1/%h", y_ch, y_valid, y, in_data[7:0]);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; y_ready = 1'b1; in_valid = 4'b1111;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_sel2_ready: got %b expected 0100", in_ready); end
      step();
      n_checks++;
      if (y !== 8'h33 || y_ch !== 2'd2 || y_valid !== 1'b1) begin
        n_fail++; $display("FAIL fixed_sel2_out: got y=%h ch=%0d v=%b expected 33/2/1", y, y_ch, y_valid);
      end
    end
    sel = 2'd1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_sel1_ready: got %b expected 0010", in_ready); end
    step();
    n_checks++;
    if (y !== 8'h22 || y_ch !== 2'd1) begin n_fail++; $display("FAIL fixed_sel1_out: got y=%h ch=%0d expected 22/1", y, y_ch); end
    // Selected channel not valid: no grant, output empties but keeps its word
    sel = 2'd2; in_valid = 4'b1011;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL fixed_nogrant_ready: got %b expected 0000", in_ready); end
    step();
    n_checks++;
    if (y_valid !== 1'b0 || y !== 8'h22 || y_ch !== 2'd1) begin
      n_fail++; $display("FAIL fixed_nogrant_out: got v=%b y=%h ch=%0d expected 0/22/1", y_valid, y, y_ch);
    end
  endtask

  task automatic test_rr_all();
    int exp_ch;
    mode = 1'b1; y_ready = 1'b1; in_valid = 4'b1111; in_data = {$urandom};
    // Fixed-mode transfers left the pointer at channel 0, so channel 1 is next
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_ptr_kept_ready: got %b expected 0010", in_ready); end
    step();
    n_checks++;
    if (y_ch !== 2'd1) begin n_fail++; $display("FAIL rr_ptr_kept: got ch=%0d expected 1", y_ch); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_ch = k % N;
      #1;
      n_checks++;
      if (in_ready !== 4'(1 << exp_ch)) begin n_fail++; $display("FAIL rr_all_ready: cycle %0d got %b expected ch %0d", k, in_ready, exp_ch); end
      step();
      n_checks++;
      if (y_ch !== 2'(exp_ch) || y_valid !== 1'b1 || y !== chan(exp_ch)) begin
        n_fail++; $display("FAIL rr_all_out: cycle %0d got ch=%0d y=%h expected ch=%0d y=%h", k, y_ch, y, exp_ch, chan(exp_ch));
      end
    end
  endtask

  task automatic test_rr_sparse();
    int seq [4] = '{3, 1, 3, 1};
    in_valid = 4'b1010; in_data = {$urandom};
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (y_ch !== 2'(seq[k]) || y_valid !== 1'b1 || y !== chan(seq[k])) begin
        n_fail++; $display("FAIL rr_sparse: cycle %0d got ch=%0d y=%h expected ch=%0d y=%h", k, y_ch, y, seq[k], chan(seq[k]));
      end
    end
    in_valid = 4'b0000;
    step();
    n_checks++;
    if (y_valid !== 1'b0 || y_ch !== 2'd1 || y !== chan(1)) begin
      n_fail++; $display("FAIL rr_empty: got v=%b ch=%0d y=%h expected 0/1/%h", y_valid, y_ch, y, chan(1));
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b1; y_ready = 1'b1; in_valid = 4'b1111; in_data = {$urandom};
    step();
    n_checks++;
    if (y_ch !== 2'd2 || y !== chan(2)) begin n_fail++; $display("FAIL bp_first: got ch=%0d y=%h expected 2/%h", y_ch, y, chan(2)); end
    y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin mode = 1'b0; sel = 2'd0; end
      else begin mode = 1'b1; end
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b expected 0000", k, in_ready); end
      step();
      n_checks++;
      if (y_valid !== 1'b1 || y_ch !== 2'd2 || y !== chan(2)) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b ch=%0d y=%h expected 1/2/%h", k, y_valid, y_ch, y, chan(2));
      end
    end
    mode = 1'b1; y_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_resume_ready: got %b expected 1000", in_ready); end
    step();
    n_checks++;
    if (y_ch !== 2'd3 || y !== chan(3)) begin n_fail++; $display("FAIL bp_resume: got ch=%0d y=%h expected 3/%h", y_ch, y, chan(3)); end
    step();
    n_checks++;
    if (y_ch !== 2'd0 || y !== chan(0)) begin n_fail++; $display("FAIL bp_wrap: got ch=%0d y=%h expected 0/%h", y_ch, y, chan(0)); end
    // Reset while a word is held
    y_ready = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0000", in_ready); end
    step();
    rst = 1'b0;
    n_checks++;
    if (y_valid !== 1'b0 || y !== 8'h00 || y_ch !== 2'd0) begin
      n_fail++; $display("FAIL midreset_out: got v=%b y=%h ch=%0d expected 0/00/0", y_valid, y, y_ch);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      mode     = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      y_ready  = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom};
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL random_ready: cycle %0d got %b expected %b", k, in_ready, exp_ready()); end
      step();
      n_checks++;
      if (y_valid !== m_valid || y !== m_y || y_ch !== 2'(m_ch)) begin
        n_fail++; $display("FAIL random_out: cycle %0d got v=%b y=%h ch=%0d expected v=%b y=%h ch=%0d", k, y_valid, y, y_ch, m_valid, m_y, m_ch);
      end
`ifdef MUX_XFER_CNT_EN
      n_checks++;
      if (xfer_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL random_cnt: cycle %0d got %0d expected %0d", k, xfer_cnt, m_cnt); end
`endif
    end
    rst = 1'b0;
  endtask

`ifdef MUX_XFER_CNT_EN
  task automatic test_xfer_cnt();
    mode = 1'b1; in_valid = 4'b1111; in_data = {$urandom}; y_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) step();
    y_ready = 1'b0;
    for (int k = 0; k < 2; k++) step();
    y_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (xfer_cnt !== 16'd8) begin n_fail++; $display("FAIL xfer_cnt_8: got %0d expected 8", xfer_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL xfer_cnt_reset: got %0d expected 0", xfer_cnt); end
  endtask
`endif

  initial begin
    m_y = '0; m_valid = 0; m_ch = 0; m_ptr = N - 1; m_cnt = 0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_random();
`ifdef MUX_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
